// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared widths and constants for the writeback arbiter
package regfile_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/dec5to32.sv
// rtl/dec5to32.sv - 5-to-32 one-hot decoder with enable
module dec5to32
  import regfile_write_arbiter_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] addr_i,
  input  logic                  en_i,
  output logic [NUM_REGS-1:0]   onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[addr_i] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// rtl/regfile_write_arbiter_rr_arbiter.sv - combinational round-robin pick starting at ptr_i
module regfile_write_arbiter_rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  int               cand;
  logic [IDX_W-1:0] cidx;
  logic             found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    cidx  = '0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      cidx = IDX_W'(cand);
      if (!found && req_i[cidx]) begin
        found       = 1'b1;
        gnt_o[cidx] = 1'b1;
        idx_o       = cidx;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin share of the register-file write port with pending-write mask
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 3,
  parameter bit ZERO_REG_DROP = 1'b1
) (
  input  logic                          clock,
  input  logic                          ctrl_reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [REG_ADDR_W*NUM_REQ-1:0] req_reg,
  input  logic [DATA_W*NUM_REQ-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          ctrl_writeEnable,
  output logic [REG_ADDR_W-1:0]         ctrl_writeReg,
  output logic [DATA_W-1:0]             data_writeReg,
  output logic [NUM_REGS-1:0]           pend_mask
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;

  logic [NUM_REQ-1:0]    gnt;
  logic [PTR_W-1:0]      gnt_idx;
  logic [REG_ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0]     sel_data;
  logic                  accept;
  logic                  drop;

  regfile_write_arbiter_rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (PTR_W)
  ) u_rr_arbiter (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign sel_reg   = req_reg[REG_ADDR_W*int'(gnt_idx) +: REG_ADDR_W];
  assign sel_data  = req_data[DATA_W*int'(gnt_idx) +: DATA_W];
  assign accept    = |gnt;
  assign drop      = ZERO_REG_DROP && (sel_reg == ZERO_REG);
  assign req_ready = ctrl_reset_n ? gnt : '0;

  // Dropped register-0 writes still advance the pointer but leave address/data untouched.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    we_d     = 1'b0;
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;
    if (accept) begin
      rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      if (!drop) begin
        we_d    = 1'b1;
        wreg_d  = sel_reg;
        wdata_d = sel_data;
      end
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      rr_ptr_q <= '0;
      we_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
    end
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;

  logic [NUM_REGS-1:0] dec_oh [NUM_REQ+1];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req_dec
    dec5to32 u_dec (
      .addr_i   (req_reg[REG_ADDR_W*i +: REG_ADDR_W]),
      .en_i     (req_valid[i]),
      .onehot_o (dec_oh[i])
    );
  end

  dec5to32 u_dec_out (
    .addr_i   (wreg_q),
    .en_i     (we_q),
    .onehot_o (dec_oh[NUM_REQ])
  );

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i <= NUM_REQ; i++) begin
      pend_mask = pend_mask | dec_oh[i];
    end
    if (ZERO_REG_DROP) begin
      pend_mask[ZERO_REG] = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench with a cycle model of the write arbiter
module tb_regfile_write_arbiter;

  localparam int N    = 3;
  localparam bit DROP = 1'b1;

  logic           clock = 1'b0;
  logic           ctrl_reset_n;
  logic [N-1:0]   req_valid;
  logic [5*N-1:0] req_reg;
  logic [32*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           ctrl_writeEnable;
  logic [4:0]     ctrl_writeReg;
  logic [31:0]    data_writeReg;
  logic [31:0]    pend_mask;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  regfile_write_arbiter #(
    .NUM_REQ       (N),
    .ZERO_REG_DROP (DROP)
  ) dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .req_valid        (req_valid),
    .req_reg          (req_reg),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .pend_mask        (pend_mask)
  );

  int          m_ptr;
  logic        m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  int          exp_g;
  logic [31:0] dut_rf [32];

  function automatic int pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] pend_model(logic [N-1:0] v, logic [5*N-1:0] r, logic we, logic [4:0] wr);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) m[r[5*i +: 5]] = 1'b1;
    end
    if (we) m[wr] = 1'b1;
    if (DROP) m[0] = 1'b0;
    return m;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  assign exp_g = ctrl_reset_n ? pick(req_valid, m_ptr) : -1;

  always @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      m_ptr  <= 0;
      m_we   <= 1'b0;
      m_reg  <= '0;
      m_data <= '0;
    end else if (exp_g < 0) begin
      m_we <= 1'b0;
    end else begin
      m_ptr <= (exp_g + 1) % N;
      if (DROP && req_reg[5*exp_g +: 5] == 5'd0) begin
        m_we <= 1'b0;
      end else begin
        m_we   <= 1'b1;
        m_reg  <= req_reg[5*exp_g +: 5];
        m_data <= req_data[32*exp_g +: 32];
      end
    end
  end

  always @(negedge clock) begin
    chk("m_ready", {29'd0, req_ready}, (exp_g < 0) ? 32'd0 : (32'd1 << exp_g));
    chk("m_we", {31'd0, ctrl_writeEnable}, {31'd0, m_we});
    chk("m_wreg", {27'd0, ctrl_writeReg}, {27'd0, m_reg});
    chk("m_wdata", data_writeReg, m_data);
    chk("m_pend", pend_mask, pend_model(req_valid, req_reg, m_we, m_reg));
    if (ctrl_writeEnable) dut_rf[ctrl_writeReg] <= data_writeReg;
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    ctrl_reset_n = 1'b0;
    req_valid    = '1;
    req_reg      = {5'd3, 5'd2, 5'd1};
    req_data     = {32'hC, 32'hB, 32'hA};
    repeat (2) @(posedge clock);
    #2;
    chk("reset_ready", {29'd0, req_ready}, 32'd0);
    chk("reset_we", {31'd0, ctrl_writeEnable}, 32'd0);
    chk("reset_wreg", {27'd0, ctrl_writeReg}, 32'd0);
    chk("reset_wdata", data_writeReg, 32'd0);

    ctrl_reset_n = 1'b1;
    #1;
    for (int c = 0; c < 6; c++) begin
      chk("fair_ready", {29'd0, req_ready}, 32'd1 << (c % 3));
      chk("fair_we", {31'd0, ctrl_writeEnable}, (c != 0) ? 32'd1 : 32'd0);
      @(posedge clock);
      #3;
    end
    chk("fair_we_last", {31'd0, ctrl_writeEnable}, 32'd1);
    chk("fair_data_last", data_writeReg, 32'hC);
    req_valid = '0;
    tick();

    req_reg[4:0]   = 5'd5;
    req_data[31:0] = 32'hDEADBEEF;
    req_valid      = 3'b001;
    #1;
    chk("single_ready", {29'd0, req_ready}, 32'd1);
    tick();
    req_valid = '0;
    chk("single_we", {31'd0, ctrl_writeEnable}, 32'd1);
    chk("single_wreg", {27'd0, ctrl_writeReg}, 32'd5);
    chk("single_wdata", data_writeReg, 32'hDEADBEEF);
    tick();
    chk("single_we_off", {31'd0, ctrl_writeEnable}, 32'd0);
    chk("single_wreg_hold", {27'd0, ctrl_writeReg}, 32'd5);

    req_reg[9:5]    = 5'd0;
    req_data[63:32] = 32'h1234;
    req_valid       = 3'b010;
    #1;
    chk("zero_ready", {29'd0, req_ready}, 32'd2);
    chk("zero_pend", pend_mask, 32'd0);
    tick();
    req_valid = '0;
    chk("zero_we", {31'd0, ctrl_writeEnable}, 32'd0);
    chk("zero_pend_after", pend_mask, 32'd0);

    req_reg[4:0]    = 5'd7;
    req_data[31:0]  = 32'd1;
    req_reg[14:10]  = 5'd7;
    req_data[95:64] = 32'd2;
    req_valid       = 3'b101;
    #1;
    chk("col_ready_first", {29'd0, req_ready}, 32'd4);
    chk("col_pend7_a", {31'd0, pend_mask[7]}, 32'd1);
    tick();
    req_valid = 3'b001;
    #1;
    chk("col_ready_second", {29'd0, req_ready}, 32'd1);
    chk("col_data_first", data_writeReg, 32'd2);
    chk("col_pend7_b", {31'd0, pend_mask[7]}, 32'd1);
    tick();
    req_valid = '0;
    #1;
    chk("col_data_second", data_writeReg, 32'd1);
    chk("col_pend7_c", {31'd0, pend_mask[7]}, 32'd1);
    tick();
    chk("col_pend7_clear", {31'd0, pend_mask[7]}, 32'd0);
    chk("col_rf7", dut_rf[7], 32'd1);

    req_reg[4:0]   = 5'd9;
    req_data[31:0] = 32'h55;
    req_valid      = 3'b001;
    #1;
    chk("mid_ready", {29'd0, req_ready}, 32'd1);
    tick();
    req_valid       = 3'b110;
    req_reg[9:5]    = 5'd10;
    req_data[63:32] = 32'h10;
    req_reg[14:10]  = 5'd11;
    req_data[95:64] = 32'h11;
    chk("mid_we_before", {31'd0, ctrl_writeEnable}, 32'd1);
    #1;
    ctrl_reset_n = 1'b0;
    #1;
    chk("mid_we_async", {31'd0, ctrl_writeEnable}, 32'd0);
    chk("mid_ready_rst", {29'd0, req_ready}, 32'd0);
    tick();
    ctrl_reset_n = 1'b1;
    #1;
    chk("post_ready_first", {29'd0, req_ready}, 32'd2);
    tick();
    req_valid = 3'b100;
    chk("post_we", {31'd0, ctrl_writeEnable}, 32'd1);
    chk("post_wreg", {27'd0, ctrl_writeReg}, 32'd10);
    chk("post_wdata", data_writeReg, 32'h10);
    #1;
    chk("post_ready_second", {29'd0, req_ready}, 32'd4);
    tick();
    req_valid = '0;
    chk("post_wreg2", {27'd0, ctrl_writeReg}, 32'd11);
    tick();
    chk("post_idle_we", {31'd0, ctrl_writeEnable}, 32'd0);

    repeat (2) @(posedge clock);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single register-file write port among NUM_REQ writeback requesters, for example the ALU, the multiply/divide unit and the load-return path. Each requester uses a valid/ready handshake. A round-robin arbiter picks one request per cycle and registers it into an output stage, which drives ctrl_writeEnable, ctrl_writeReg and data_writeReg on the register file. The block also exports a pending-write mask so stall/hazard logic can see which registers are about to change.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
ZERO_REG_DROP, 1, 1 = writes to register 0 are accepted but never issued to the register file

Ports:
clock  input  1  system clock, all state on rising edge
ctrl_reset_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester write request valid
req_reg  input  5*NUM_REQ  packed destination register; requester i uses bits [5i+4:5i]
req_data  input  32*NUM_REQ  packed write data; requester i uses bits [32i+31:32i]
req_ready  output  NUM_REQ  per-requester grant/accept (combinational)
ctrl_writeEnable  output  1  register-file write enable (registered)
ctrl_writeReg  output  5  register-file write address (registered)
data_writeReg  output  32  register-file write data (registered)
pend_mask  output  32  one-hot OR of registers with an outstanding or issuing write

Behaviour:
- Reset (ctrl_reset_n=0, asynchronous):
  - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, rr_ptr=0.
  - req_ready forced to 0 while reset is asserted.
- Handshake:
  - A request is accepted in a cycle where req_valid[i]=1 and req_ready[i]=1.
  - Once req_valid[i] is raised, the requester holds req_reg and req_data stable and keeps valid high until accepted.
  - req_ready depends only on req_valid and rr_ptr, never on req_reg or req_data.
- Arbitration:
  - At most one req_ready bit is high per cycle.
  - Priority is scanned from rr_ptr upward, modulo NUM_REQ; the first valid requester wins.
  - After granting requester g, rr_ptr <= (g+1) mod NUM_REQ.
  - With no valid requests, rr_ptr holds.
  - No requester waits more than NUM_REQ-1 grants.
- Output stage:
  - The accepted request is registered at the accepting edge.
  - In the next cycle ctrl_writeEnable=1 for exactly one cycle, with ctrl_writeReg and data_writeReg carrying the accepted values.
  - Latency from accept to write enable is 1 cycle; throughput is 1 write per cycle with no bubbles.
  - The register file always accepts, so there is no backpressure on the output stage.
  - When no grant occurs, ctrl_writeEnable <= 0. ctrl_writeReg and data_writeReg hold their last values.
- Register 0:
  - With ZERO_REG_DROP=1, a request to register 0 is granted and consumes a round-robin slot.
  - The following cycle ctrl_writeEnable stays 0.
- pend_mask:
  - Combinational OR of the one-hot decode of req_reg[i] for every i with req_valid[i]=1, plus the one-hot decode of ctrl_writeReg when ctrl_writeEnable=1.
  - Bit 0 is always 0 when ZERO_REG_DROP=1.
- Same-register collisions: no merging. Each write is issued in grant order, so the last granted write determines the final register value.
- Reset mid-operation:
  - An in-flight output-stage write is cancelled immediately; ctrl_writeEnable drops asynchronously.
  - Requesters that still have valid high are arbitrated from rr_ptr=0 after reset release.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5, DATA_W=32, NUM_REGS=32.
  - The zero-register index constant.
- Natural sub-module: rr_arbiter. Inputs are the request vector and rr_ptr; outputs are the one-hot grant and the encoded index. It is purely combinational and instantiated once.
- The one-hot decodes for pend_mask reuse the existing 5-to-32 decoder module.

Test Plan:
- Reset: hold ctrl_reset_n=0 with all req_valid=1 -> req_ready=0, ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
- Single write: req0 valid, reg 5, data 0xDEADBEEF at cycle t -> req_ready[0]=1 at t; ctrl_writeEnable=1, ctrl_writeReg=5, data 0xDEADBEEF at t+1; ctrl_writeEnable=0 at t+2.
- Fairness: requesters 0,1,2 all valid continuously from reset -> grant order 0,1,2,0,1,2; ctrl_writeEnable=1 every cycle from the second cycle on.
- Zero-register drop: req1 valid, reg 0, data 0x1234 -> req_ready[1]=1; ctrl_writeEnable stays 0 next cycle; pend_mask=0 throughout.
- Collision: rr_ptr=2; req0 (reg 7, data 1) and req2 (reg 7, data 2) both valid -> req2 granted first, then req0; register 7 finally holds 1; pend_mask[7]=1 for 3 consecutive cycles.
- Mid-operation reset: assert ctrl_reset_n=0 while ctrl_writeEnable=1 -> ctrl_writeEnable=0 immediately, not at the next edge. After release with req1 and req2 valid, req1 is granted first (rr_ptr=0).
